// File: rtl/detect_count_display_if.sv
// Detector-to-counter bus: strobe/hit inputs, count and display outputs.
// One interface instance per counter/display stage.
interface detect_count_display_if;
  logic        step;
  logic        z;
  logic        clr;
  logic [15:0] count_bcd;
  logic        hit;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output step, z, clr,
    input  count_bcd, hit, ovf, an, seg, dp
  );

  modport slave (
    input  step, z, clr,
    output count_bcd, hit, ovf, an, seg, dp
  );
endinterface

// File: rtl/detect_count_display.sv
// BCD hit counter (0000-9999) with a registered 4-digit
// multiplexed 7-segment scanner.
module detect_count_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit WRAP        = 1'b1,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rest,
  detect_count_display_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  logic [15:0]   count_q, count_d;
  logic          hit_q, hit_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] ref_q, ref_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [15:0]   inc_val;
  logic          carry;
  logic          inc;
  logic [3:0]    digit;
  logic          blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign inc = bus.step & bus.z;

  // Ripple-carry BCD increment, one nibble at a time
  always_comb begin
    inc_val = count_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    hit_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (inc) begin
      hit_d = 1'b1;
      if (count_q == 16'h9999) begin
        ovf_d   = 1'b1;
        count_d = WRAP ? 16'h0000 : count_q;
      end else begin
        count_d = inc_val;
      end
    end
  end

  always_comb begin
    ref_d = ref_q + CW'(1);
    idx_d = idx_q;
    if (ref_q == TERM) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Digit and anode come from the same index, so they switch together
  always_comb begin
    digit = count_q[4*idx_q +: 4];
    blank = 1'b0;
    case (idx_q)
      2'd1:    blank = (count_q[15:4] == 12'h000);
      2'd2:    blank = (count_q[15:8] == 8'h00);
      2'd3:    blank = (count_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    blank = blank & BLANK_LZ;
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : seg7(digit);
    dp_d  = ~((idx_q == 2'd3) & ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      count_q <= '0;
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.hit       = hit_q;
  assign bus.ovf       = ovf_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;

endmodule

// File: tb/tb_detect_count_display.sv
// Directed bench: two instances (wrap and saturate), fast
// refresh so the scan sequence is observable.
module tb_detect_count_display;

  logic clk;
  logic rest;
  int   n_tests;
  int   n_fail;

  detect_count_display_if ia ();
  detect_count_display_if ib ();

  detect_count_display #(
    .REFRESH_DIV(4), .WRAP(1'b1), .BLANK_LZ(1'b1)
  ) u_wrap (
    .clk(clk), .rest(rest), .bus(ia)
  );

  detect_count_display #(
    .REFRESH_DIV(4), .WRAP(1'b0), .BLANK_LZ(1'b1)
  ) u_sat (
    .clk(clk), .rest(rest), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic zz,
                       input logic c);
    ia.step = s; ia.z = zz; ia.clr = c;
    ib.step = s; ib.z = zz; ib.clr = c;
  endtask

  task automatic inc_n(input int n);
    drive(1'b1, 1'b1, 1'b0);
    repeat (n) tick();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  logic [16:0] pat;
  logic [3:0]  exp_an [4];
  logic [6:0]  exp_seg [4];
  int          hits;
  logic [3:0]  prev_an;
  bit          found;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rest    = 1'b0;
    drive(1'b1, 1'b1, 1'b0);

    // 1: reset holds everything despite step=z=1
    repeat (3) tick();
    check("rst_count", ia.count_bcd, 16'h0000);
    check("rst_hit", ia.hit, 1'b0);
    check("rst_ovf", ia.ovf, 1'b0);
    check("rst_an", ia.an, 4'b1111);
    check("rst_seg", ia.seg, 7'h7F);
    check("rst_dp", ia.dp, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    rest = 1'b1;
    tick();
    check("first_an", ia.an, 4'b1110);
    check("first_cnt", ia.count_bcd, 16'h0000);

    // 2: 12 accepted strobes, 5 rejected, idle z between
    pat  = 17'b1_1011_0111_0110_1101;
    hits = 0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, pat[i], 1'b0);
      tick();
      hits += int'(ia.hit);
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      tick();
      hits += int'(ia.hit);
    end
    check("hits12", hits, 12);
    check("cnt12", ia.count_bcd, 16'h0012);
    hits = 0;
    drive(1'b0, 1'b1, 1'b0);
    repeat (50) begin
      tick();
      hits += int'(ia.hit);
    end
    drive(1'b0, 1'b0, 1'b0);
    check("nostep_hits", hits, 0);
    check("nostep_cnt", ia.count_bcd, 16'h0012);

    // 3: carry chain
    clear();
    check("clr_cnt", ia.count_bcd, 16'h0000);
    inc_n(9);
    check("c0009", ia.count_bcd, 16'h0009);
    inc_n(1);
    check("c0010", ia.count_bcd, 16'h0010);
    clear();
    inc_n(99);
    check("c0099", ia.count_bcd, 16'h0099);
    inc_n(1);
    check("c0100", ia.count_bcd, 16'h0100);
    clear();
    inc_n(999);
    check("c0999", ia.count_bcd, 16'h0999);
    inc_n(1);
    check("c1000", ia.count_bcd, 16'h1000);

    // 4: top of range, wrap versus saturate
    clear();
    inc_n(9999);
    check("a9999", ia.count_bcd, 16'h9999);
    check("b9999", ib.count_bcd, 16'h9999);
    check("a_ovf0", ia.ovf, 1'b0);
    inc_n(1);
    check("wrap_cnt", ia.count_bcd, 16'h0000);
    check("wrap_ovf", ia.ovf, 1'b1);
    check("wrap_hit", ia.hit, 1'b1);
    check("sat_cnt", ib.count_bcd, 16'h9999);
    check("sat_ovf", ib.ovf, 1'b1);
    check("sat_hit", ib.hit, 1'b1);
    tick();
    check("hit_pulse", ia.hit, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ia.an == 4'b0111) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("dp_sync", found, 1'b1);
    check("dp_on", ia.dp, 1'b0);

    // 5: clr beats inc, clears ovf
    inc_n(42);
    check("c0042", ia.count_bcd, 16'h0042);
    check("ovf42", ia.ovf, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("clrinc_cnt", ia.count_bcd, 16'h0000);
    check("clrinc_hit", ia.hit, 1'b0);
    check("clrinc_ovf", ia.ovf, 1'b0);

    // 6: scan at 0012 with leading-zero blanking
    inc_n(12);
    exp_an[0] = 4'b1110; exp_seg[0] = 7'b0100100;
    exp_an[1] = 4'b1101; exp_seg[1] = 7'b1111001;
    exp_an[2] = 4'b1011; exp_seg[2] = 7'h7F;
    exp_an[3] = 4'b0111; exp_seg[3] = 7'h7F;
    tick();
    prev_an = ia.an;
    found   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ia.an == 4'b1110 && prev_an != 4'b1110) begin
        found = 1'b1;
        break;
      end
      prev_an = ia.an;
    end
    check("scan_sync", found, 1'b1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("an_d%0d_c%0d", d, c),
              ia.an, exp_an[d]);
        check($sformatf("seg_d%0d_c%0d", d, c),
              ia.seg, exp_seg[d]);
        check($sformatf("dp_d%0d_c%0d", d, c),
              ia.dp, 1'b1);
        tick();
      end
    end
    check("scan_wrap_an", ia.an, 4'b1110);

    // mid-scan reset
    tick();
    rest = 1'b0;
    tick();
    check("mid_rst_an", ia.an, 4'b1111);
    check("mid_rst_seg", ia.seg, 7'h7F);
    check("mid_rst_cnt", ia.count_bcd, 16'h0000);
    rest = 1'b1;
    tick();
    check("post_rst_an", ia.an, 4'b1110);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
